// File: rtl/stack_arbiter.sv
// Two-client push/pop sequencer for the shared stack; ack lands RESP_WAIT+2 cycles after a request is seen in IDLE.
// Clients hold req until ack (no other backpressure); define STACK_ARB_RR_EN for round-robin, else client 0 has fixed priority.
module stack_arbiter #(
  parameter int DATA_W    = 8,
  parameter int RESP_WAIT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              op0,
  input  logic              op1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              rerr,
  output logic              grant_id,
  output logic              busy,
  output logic              stack_push,
  output logic              stack_pop,
  output logic [DATA_W-1:0] stack_data_in,
  input  logic [DATA_W-1:0] stack_data_out,
  input  logic              stack_error
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        grant_vld;
  logic        pick;
  logic        pick_op;
  logic [DATA_W-1:0] pick_wdata;

  assign grant_vld  = req0 | req1;
  assign pick_op    = pick ? op1 : op0;
  assign pick_wdata = pick ? wdata1 : wdata0;

`ifdef STACK_ARB_RR_EN
  logic last_grant;

  // A lone requester wins; a contest goes to the client not served last.
  assign pick = (req0 && req1) ? ~last_grant : req1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_grant <= 1'b1;
    else if (state == IDLE && grant_vld)
      last_grant <= pick;
  end
`else
  assign pick = ~req0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered against the state being entered, so pulses align with ISSUE/DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt           <= 4'd0;
      ack0          <= 1'b0;
      ack1          <= 1'b0;
      rdata         <= '0;
      rerr          <= 1'b0;
      grant_id      <= 1'b0;
      busy          <= 1'b0;
      stack_push    <= 1'b0;
      stack_pop     <= 1'b0;
      stack_data_in <= '0;
    end else begin
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      stack_push <= 1'b0;
      stack_pop  <= 1'b0;
      busy       <= (state_nxt != IDLE);
      case (state)
        IDLE: if (grant_vld) begin
          grant_id      <= pick;
          stack_data_in <= pick_wdata;
          stack_push    <= ~pick_op;
          stack_pop     <= pick_op;
        end
        ISSUE: cnt <= 4'(RESP_WAIT - 1);
        WAIT: begin
          if (cnt == 4'd0) begin
            rdata <= stack_data_out;
            rerr  <= stack_error;
            ack0  <= ~grant_id;
            ack1  <= grant_id;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter with a behavioural 32-deep stack attached.
module tb_stack_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1, op0, op1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1, rerr, grant_id, busy, stack_push, stack_pop;
  logic [7:0] rdata, stack_data_in, stack_data_out;
  logic       stack_error;

  int checks = 0;
  int errors = 0;
  int n_push = 0, n_pop = 0, n_pulse_both = 0, n_ack_both = 0;

  always #5 clk = ~clk;

  stack_arbiter #(.DATA_W(8), .RESP_WAIT(2)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .rerr(rerr),
    .grant_id(grant_id), .busy(busy),
    .stack_push(stack_push), .stack_pop(stack_pop),
    .stack_data_in(stack_data_in),
    .stack_data_out(stack_data_out), .stack_error(stack_error)
  );

  logic [7:0] mem [32];
  logic [5:0] sp;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sp             <= 6'd0;
      stack_error    <= 1'b0;
      stack_data_out <= 8'h00;
    end else if (stack_push) begin
      if (sp == 6'd32) stack_error <= 1'b1;
      else begin
        mem[sp[4:0]] <= stack_data_in;
        sp           <= sp + 6'd1;
        stack_error  <= 1'b0;
      end
    end else if (stack_pop) begin
      if (sp == 6'd0) stack_error <= 1'b1;
      else begin
        stack_data_out <= mem[5'(sp - 6'd1)];
        sp             <= sp - 6'd1;
        stack_error    <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (stack_push) n_push <= n_push + 1;
    if (stack_pop) n_pop <= n_pop + 1;
    if (stack_push && stack_pop) n_pulse_both <= n_pulse_both + 1;
    if (ack0 && ack1) n_ack_both <= n_ack_both + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(output logic which, output int lat, output logic to);
    which = 1'b0;
    lat   = 0;
    to    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      lat++;
      if (ack0 || ack1) begin
        which = ack1;
        to    = 1'b0;
        break;
      end
    end
    if (to) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout observed none expected ack within 20 cycles");
    end
  endtask

  task automatic do_txn(input logic c, input logic op, input logic [7:0] wd,
                        output logic which, output int lat, output logic to);
    if (c) begin req1 = 1'b1; op1 = op; wdata1 = wd; end
    else   begin req0 = 1'b1; op0 = op; wdata0 = wd; end
    wait_ack(which, lat, to);
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
  endtask

  logic       which, to;
  int         lat, p0, bad;
  logic [3:0] order;

  initial begin
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; op0 = 1'b0; op1 = 1'b0;
    wdata0 = 8'h00; wdata1 = 8'h00;
    repeat (2) tick();
    chk("rst_flags", 32'({ack0, ack1, rerr, grant_id, busy, stack_push, stack_pop}), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_data_in", 32'(stack_data_in), 32'd0);
    reset = 1'b0;
    tick();

    // Pop on an empty stack: error reported, still acked, one pulse only.
    do_txn(1'b1, 1'b1, 8'h00, which, lat, to);
    chk("empty_pop_who", 32'(which), 32'd1);
    chk("empty_pop_lat", 32'(lat), 32'd4);
    chk("empty_pop_rerr", 32'(rerr), 32'd1);
    repeat (4) tick();
    chk("empty_pop_pulses", 32'(n_pop), 32'd1);

    // Single push, cycle by cycle.
    req0 = 1'b1; op0 = 1'b0; wdata0 = 8'h5A;
    tick();
    chk("push_c1_pulse", 32'({stack_push, stack_pop}), 32'b10);
    chk("push_c1_data", 32'(stack_data_in), 32'h5A);
    chk("push_c1_busy_gid", 32'({busy, grant_id}), 32'b10);
    tick();
    chk("push_c2_pulse", 32'({stack_push, stack_pop}), 32'b00);
    tick();
    chk("push_c3_ack", 32'({ack0, ack1}), 32'b00);
    tick();
    chk("push_c4_ack", 32'({ack0, ack1}), 32'b10);
    chk("push_c4_rerr", 32'(rerr), 32'd0);
    chk("push_c4_data_held", 32'(stack_data_in), 32'h5A);
    req0 = 1'b0;
    tick();
    chk("push_idle_busy", 32'(busy), 32'd0);

    // Client 0 pushes, client 1 pops it back.
    do_txn(1'b0, 1'b0, 8'h3C, which, lat, to);
    do_txn(1'b1, 1'b1, 8'h00, which, lat, to);
    chk("pop_who", 32'(which), 32'd1);
    chk("pop_rdata", 32'(rdata), 32'h3C);
    chk("pop_rerr", 32'(rerr), 32'd0);

    // Both clients hold requests across four transactions.
    req0 = 1'b1; op0 = 1'b0; wdata0 = 8'h10;
    req1 = 1'b1; op1 = 1'b0; wdata1 = 8'h20;
    order = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      wait_ack(which, lat, to);
      order[k] = which;
    end
    req0 = 1'b0;
`ifdef STACK_ARB_RR_EN
    chk("contest_order", 32'(order), 32'b1010);
`else
    chk("contest_order", 32'(order), 32'b0000);
`endif
    wait_ack(which, lat, to);
    chk("pending_req1_served", 32'(which), 32'd1);
    req1 = 1'b0;
    tick();

    // Fill to 32 entries (6 held), then overflow.
    bad = 0;
    for (int i = 0; i < 26; i++) begin
      do_txn(1'b0, 1'b0, 8'(i), which, lat, to);
      if (rerr !== 1'b0 || to !== 1'b0 || which !== 1'b0) bad++;
    end
    chk("fill_no_err", 32'(bad), 32'd0);
    do_txn(1'b0, 1'b0, 8'hFF, which, lat, to);
    chk("overflow_rerr", 32'(rerr), 32'd1);
    chk("overflow_ack_who", 32'(which), 32'd0);
    chk("push_pulse_total", 32'(n_push), 32'd34);
    chk("pop_pulse_total", 32'(n_pop), 32'd2);

    // Reset asserted during the ISSUE cycle.
    req0 = 1'b1; op0 = 1'b0; wdata0 = 8'h77;
    tick();
    chk("rst_mid_issue", 32'(stack_push), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_clear", 32'({stack_push, busy, ack0}), 32'd0);
    p0 = n_push;
    repeat (3) tick();
    chk("rst_mid_no_ack", 32'({ack0, ack1, busy}), 32'd0);
    reset = 1'b0;
    wait_ack(which, lat, to);
    chk("rst_reserve_who", 32'(which), 32'd0);
    chk("rst_reserve_lat", 32'(lat), 32'd4);
    chk("rst_reserve_pulses", 32'(n_push - p0), 32'd1);
    chk("rst_reserve_rerr", 32'(rerr), 32'd0);
    req0 = 1'b0;
    repeat (2) tick();

    chk("pulse_exclusive", 32'(n_pulse_both), 32'd0);
    chk("ack_exclusive", 32'(n_ack_both), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
